axi_mm_ll_rx_credit_fifo: RTL and testbench

Receive-side logic-link buffer for one AXI channel: ar, aw or w on the slave side, or r and b on the master side.
- Captures words pushed from the AIB receive path and presents them show-ahead as user_valid/rxfifo_data to the channel packet-gen stage.
- Returns one credit pulse to the far-end transmitter for every word consumed.
- Instantiated once per channel; WIDTH is set to the channel packet width (e.g. 49 for ar/aw, 149 for w).

---
 rtl/axi_mm_ll_pkg.sv | 23 ++
 rtl/axi_mm_ll_rx_mem.sv | 29 ++
 rtl/axi_mm_ll_rx_credit_fifo.sv | 104 ++++++++++
 tb/tb_axi_mm_ll_rx_credit_fifo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mm_ll_pkg.sv
// Purpose: shared constants for the AXI-MM logic-link channel buffers.
// Latency: n/a (constants and a compile-time helper only).
// Backpressure: n/a.
// Ports: none. Holds the channel packet widths, the default receive credit
// depth and the pointer-width helper used to size wrap-bit pointers.
package axi_mm_ll_pkg;

  // Channel packet widths in bits.
  localparam int AR_W = 49;
  localparam int AW_W = 49;
  localparam int W_W  = 149;
  localparam int R_W  = 135;
  localparam int B_W  = 6;

  // Receive buffer depth; the far-end transmitter starts with this many credits.
  localparam int LL_RX_DEPTH = 8;

  // Width of a FIFO pointer including the extra wrap bit.
  function automatic int ll_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axi_mm_ll_rx_mem.sv
// Purpose: DEPTH x WIDTH storage array for the logic-link receive FIFO.
// Latency: write lands on the next clk edge; read is combinational.
// Backpressure: none; the caller decides when writes are legal.
// Ports: clk, wr_en/wr_addr/wr_data write port, rd_addr/rd_data read port.
// Contents are deliberately not reset; the owner gates validity.
module axi_mm_ll_rx_mem #(
  parameter int WIDTH  = 149,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axi_mm_ll_rx_credit_fifo.sv
// Purpose: logic-link receive buffer for one AXI channel with credit return.
// Latency: push visible one cycle later (show-ahead); credit one cycle after pop.
// Backpressure: none upstream (credit based); a push while full is dropped and flagged.
// Ports:
//   clk_wr, rst_wr_n        clock and synchronous active-low reset
//   rx_online               link up; low flushes the buffer and suppresses credits
//   rxfifo_i_push/_data     one-cycle write strobe and word from the AIB receive path
//   user_valid/rxfifo_data  head word presented to packet-gen, show-ahead
//   user_ready              consumer accepts the head word
//   tx_i_credit             one-cycle credit pulse per consumed word
//   rx_overflow_sticky      push arrived while full; cleared only by reset
//   rx_fifo_level           occupancy 0..DEPTH
module axi_mm_ll_rx_credit_fifo
  import axi_mm_ll_pkg::*;
#(
  parameter  int WIDTH  = W_W,
  parameter  int DEPTH  = LL_RX_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_wr,
  input  logic              rst_wr_n,
  input  logic              rx_online,
  input  logic              rxfifo_i_push,
  input  logic [WIDTH-1:0]  rxfifo_i_data,
  output logic              user_valid,
  output logic [WIDTH-1:0]  rxfifo_data,
  input  logic              user_ready,
  output logic              tx_i_credit,
  output logic              rx_overflow_sticky,
  output logic [ADDR_W:0]   rx_fifo_level
);

  localparam int PTR_W = ll_ptr_w(DEPTH);

  // Pointers carry a wrap bit above the index so full and empty are distinct.
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_nxt;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;

  logic empty;
  logic full;
  logic pop;
  logic push_acc;
  logic push_drop;

  assign wr_idx = wr_ptr[ADDR_W-1:0];
  assign rd_idx = rd_ptr[ADDR_W-1:0];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_idx == rd_idx) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  // Valid comes only from registered pointers, so user_ready never reaches it.
  assign user_valid = !empty;

  assign pop = user_valid && user_ready;

  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push_acc  = rxfifo_i_push && rx_online && (!full || pop);
  assign push_drop = rxfifo_i_push && rx_online && full && !pop;

  assign wr_ptr_nxt = wr_ptr + {{ADDR_W{1'b0}}, push_acc};
  assign rd_ptr_nxt = rd_ptr + {{ADDR_W{1'b0}}, pop};

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      tx_i_credit        <= 1'b0;
      rx_overflow_sticky <= 1'b0;
      rx_fifo_level      <= '0;
    end else if (!rx_online) begin
      // Link down: drop everything held; the far end rebuilds its credits on link-up.
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      tx_i_credit   <= 1'b0;
      rx_fifo_level <= '0;
    end else begin
      wr_ptr        <= wr_ptr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      tx_i_credit   <= pop;
      rx_fifo_level <= wr_ptr_nxt - rd_ptr_nxt;
      if (push_drop) begin
        rx_overflow_sticky <= 1'b1;
      end
    end
  end

  axi_mm_ll_rx_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk_wr),
    .wr_en   (push_acc),
    .wr_addr (wr_idx),
    .wr_data (rxfifo_i_data),
    .rd_addr (rd_idx),
    .rd_data (rxfifo_data)
  );

endmodule

// File: tb/tb_axi_mm_ll_rx_credit_fifo.sv
// Purpose: self-checking bench for axi_mm_ll_rx_credit_fifo.
// Latency: a queue model advanced on each rising edge; outputs compared on falling edges.
// Backpressure: driven directly by the directed stimulus on user_ready.
module tb_axi_mm_ll_rx_credit_fifo;
  import axi_mm_ll_pkg::*;

  localparam int WIDTH  = W_W;
  localparam int DEPTH  = LL_RX_DEPTH;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk_wr = 1'b0;
  logic              rst_wr_n;
  logic              rx_online;
  logic              rxfifo_i_push;
  logic [WIDTH-1:0]  rxfifo_i_data;
  logic              user_valid;
  logic [WIDTH-1:0]  rxfifo_data;
  logic              user_ready;
  logic              tx_i_credit;
  logic              rx_overflow_sticky;
  logic [ADDR_W:0]   rx_fifo_level;

  always #5 clk_wr = ~clk_wr;

  axi_mm_ll_rx_credit_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk_wr             (clk_wr),
    .rst_wr_n           (rst_wr_n),
    .rx_online          (rx_online),
    .rxfifo_i_push      (rxfifo_i_push),
    .rxfifo_i_data      (rxfifo_i_data),
    .user_valid         (user_valid),
    .rxfifo_data        (rxfifo_data),
    .user_ready         (user_ready),
    .tx_i_credit        (tx_i_credit),
    .rx_overflow_sticky (rx_overflow_sticky),
    .rx_fifo_level      (rx_fifo_level)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int credit_cnt = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of held words plus the expected credit and sticky flag.
  logic [WIDTH-1:0] m_q[$];
  bit m_credit = 1'b0;
  bit m_sticky = 1'b0;
  bit m_pop;
  bit m_full;

  always @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      m_q.delete();
      m_credit = 1'b0;
      m_sticky = 1'b0;
    end else if (!rx_online) begin
      m_q.delete();
      m_credit = 1'b0;
    end else begin
      m_full   = (m_q.size() == DEPTH);
      m_pop    = (m_q.size() != 0) && user_ready;
      m_credit = m_pop;
      if (m_pop) void'(m_q.pop_front());
      if (rxfifo_i_push) begin
        if (m_full && !m_pop) m_sticky = 1'b1;
        else m_q.push_back(rxfifo_i_data);
      end
    end
  end

  always @(negedge clk_wr) begin
    if (chk_en) begin
      chk("user_valid", WIDTH'(user_valid), WIDTH'(m_q.size() != 0));
      if (m_q.size() != 0) chk("rxfifo_data", rxfifo_data, m_q[0]);
      chk("rx_fifo_level", WIDTH'(rx_fifo_level), WIDTH'(m_q.size()));
      chk("tx_i_credit", WIDTH'(tx_i_credit), WIDTH'(m_credit));
      chk("rx_overflow_sticky", WIDTH'(rx_overflow_sticky), WIDTH'(m_sticky));
    end
  end

  // Apply one cycle of inputs; returns at the following falling edge.
  task automatic tick(input bit p, input logic [WIDTH-1:0] d, input bit r,
                      input bit on = 1'b1, input bit rst_n = 1'b1);
    rxfifo_i_push = p;
    rxfifo_i_data = d;
    user_ready    = r;
    rx_online     = on;
    rst_wr_n      = rst_n;
    @(posedge clk_wr);
    @(negedge clk_wr);
    if (tx_i_credit === 1'b1) credit_cnt++;
  endtask

  int c0;
  int nxt;

  initial begin
    rst_wr_n      = 1'b0;
    rx_online     = 1'b1;
    rxfifo_i_push = 1'b0;
    rxfifo_i_data = '0;
    user_ready    = 1'b0;

    tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk_en = 1'b1;
    chk("rst_valid",  WIDTH'(user_valid), '0);
    chk("rst_level",  WIDTH'(rx_fifo_level), '0);
    chk("rst_credit", WIDTH'(tx_i_credit), '0);
    chk("rst_sticky", WIDTH'(rx_overflow_sticky), '0);

    // Single push with ready held high.
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    c0 = credit_cnt;
    tick(1'b1, WIDTH'(1), 1'b1);
    chk("t1_valid", WIDTH'(user_valid), WIDTH'(1));
    chk("t1_data", rxfifo_data, WIDTH'(1));
    chk("t1_credit_early", WIDTH'(tx_i_credit), '0);
    tick(1'b0, '0, 1'b1);
    chk("t1_credit", WIDTH'(tx_i_credit), WIDTH'(1));
    chk("t1_level", WIDTH'(rx_fifo_level), '0);
    tick(1'b0, '0, 1'b0);
    chk("t1_credit_off", WIDTH'(tx_i_credit), '0);
    chk("t1_credit_total", WIDTH'(credit_cnt - c0), WIDTH'(1));

    // Fill then drain.
    for (int i = 0; i < 8; i++) tick(1'b1, WIDTH'(i), 1'b0);
    chk("t2_level_full", WIDTH'(rx_fifo_level), WIDTH'(8));
    chk("t2_valid_full", WIDTH'(user_valid), WIDTH'(1));
    c0 = credit_cnt;
    for (int i = 0; i < 8; i++) begin
      chk("t2_order", rxfifo_data, WIDTH'(i));
      tick(1'b0, '0, 1'b1);
      chk("t2_credit_run", WIDTH'(tx_i_credit), WIDTH'(1));
    end
    chk("t2_level_empty", WIDTH'(rx_fifo_level), '0);
    chk("t2_credit_total", WIDTH'(credit_cnt - c0), WIDTH'(8));
    tick(1'b0, '0, 1'b0);

    // Overflow, then push at full with a simultaneous pop.
    for (int i = 0; i < 8; i++) tick(1'b1, WIDTH'(i), 1'b0);
    tick(1'b1, WIDTH'('hAA), 1'b0);
    chk("t3_level_ovf", WIDTH'(rx_fifo_level), WIDTH'(8));
    chk("t3_sticky", WIDTH'(rx_overflow_sticky), WIDTH'(1));
    tick(1'b0, '0, 1'b0);
    chk("t3_sticky_hold", WIDTH'(rx_overflow_sticky), WIDTH'(1));
    tick(1'b1, WIDTH'('hBB), 1'b1);
    chk("t3_level_pushpop", WIDTH'(rx_fifo_level), WIDTH'(8));
    for (int i = 1; i < 8; i++) begin
      chk("t3_order", rxfifo_data, WIDTH'(i));
      tick(1'b0, '0, 1'b1);
    end
    chk("t3_bb", rxfifo_data, WIDTH'('hBB));
    tick(1'b0, '0, 1'b1);
    chk("t3_level_empty", WIDTH'(rx_fifo_level), '0);

    // Wrap-around at level 3, starting from a clean sticky flag.
    tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("t4_sticky_clr", WIDTH'(rx_overflow_sticky), '0);
    c0 = credit_cnt;
    for (int i = 0; i < 3; i++) tick(1'b1, WIDTH'(i), 1'b0);
    chk("t4_level3", WIDTH'(rx_fifo_level), WIDTH'(3));
    nxt = 0;
    for (int i = 3; i < 20; i++) begin
      chk("t4_order", rxfifo_data, WIDTH'(nxt));
      tick(1'b1, WIDTH'(i), 1'b1);
      nxt++;
      chk("t4_level_hold", WIDTH'(rx_fifo_level), WIDTH'(3));
    end
    for (int i = 0; i < 3; i++) begin
      chk("t4_order_tail", rxfifo_data, WIDTH'(nxt));
      tick(1'b0, '0, 1'b1);
      nxt++;
    end
    tick(1'b0, '0, 1'b0);
    chk("t4_credit_total", WIDTH'(credit_cnt - c0), WIDTH'(20));
    chk("t4_no_ovf", WIDTH'(rx_overflow_sticky), '0);

    // Flush by dropping the link for one cycle.
    for (int i = 0; i < 5; i++) tick(1'b1, WIDTH'('h100 + i), 1'b0);
    chk("t5_level5", WIDTH'(rx_fifo_level), WIDTH'(5));
    tick(1'b1, WIDTH'('h77), 1'b1, 1'b0);
    chk("t5_valid", WIDTH'(user_valid), '0);
    chk("t5_level", WIDTH'(rx_fifo_level), '0);
    chk("t5_credit", WIDTH'(tx_i_credit), '0);
    tick(1'b1, WIDTH'('h55), 1'b0, 1'b1);
    chk("t5_new_valid", WIDTH'(user_valid), WIDTH'(1));
    chk("t5_new_data", rxfifo_data, WIDTH'('h55));
    chk("t5_new_level", WIDTH'(rx_fifo_level), WIDTH'(1));

    // Reset mid-operation with the sticky flag set and four words held.
    for (int i = 0; i < 7; i++) tick(1'b1, WIDTH'('h200 + i), 1'b0);
    tick(1'b1, WIDTH'('hEE), 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b0);
    chk("t6_level4", WIDTH'(rx_fifo_level), WIDTH'(4));
    chk("t6_sticky_set", WIDTH'(rx_overflow_sticky), WIDTH'(1));
    c0 = credit_cnt;
    tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("t6_valid", WIDTH'(user_valid), '0);
    chk("t6_level", WIDTH'(rx_fifo_level), '0);
    chk("t6_sticky", WIDTH'(rx_overflow_sticky), '0);
    chk("t6_credit", WIDTH'(tx_i_credit), '0);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    chk("t6_no_credits", WIDTH'(credit_cnt - c0), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
